// File: rtl/vpg_timing_gen.sv
// -----------------------------------------------------------------------------
// vpg_timing_gen
// Video timing generator for the pattern generator / video output path.
// Produces hsync, vsync, data enable and active-area pixel coordinates for
// three fixed VESA modes. A mode change blanks the output for SETTLE_CYCLES
// pixel clocks (PLL retune time) and then restarts at the top-left pixel.
//
// Parameters:
//   SETTLE_CYCLES   blank pixel clocks after a mode change (>= 1)
//
// Ports:
//   clk              in   pixel clock
//   reset_n          in   asynchronous active-low reset
//   vpg_mode_change  in   one-cycle strobe, latches vpg_mode and restarts
//   vpg_mode[3:0]    in   0=640x480p60, 1=800x600p60, 2=1024x768p60
//   hsync            out  horizontal sync (mode polarity)
//   vsync            out  vertical sync (mode polarity)
//   de               out  active video data enable
//   x[11:0], y[11:0] out  active-area pixel position, 0 outside active video
//   frame_start      out  one-cycle pulse with the first de of each frame
//   mode_valid       out  latched mode code is supported
//
// Build option:
//   VTG_PIXEL_POS_EN  when defined, x/y are generated; otherwise they are tied
//                     to 0 and their registers are not built.
//
// All outputs are registered and reflect the counter state of the previous
// cycle.
// -----------------------------------------------------------------------------
module vpg_timing_gen #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vpg_mode_change,
  input  logic [3:0]  vpg_mode,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        mode_valid
);

  localparam logic [1:0] S_SETTLE  = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_INVALID = 2'd2;

  // Settle counter only needs to hold SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_mode;
  logic [SW-1:0] r_settle;
  logic [11:0]   r_h_cnt;
  logic [11:0]   r_v_cnt;

  // Mode timing: active end, sync start, sync end, total (per axis), polarity.
  logic [11:0] w_h_act, w_h_ss, w_h_se, w_h_tot;
  logic [11:0] w_v_act, w_v_ss, w_v_se, w_v_tot;
  logic        w_pol;
  logic        w_supported;

  // Mode parameter lookup; unsupported codes borrow mode 0 geometry so the
  // settle-window sync level stays defined.
  always_comb begin
    w_h_act = 12'd640;  w_h_ss = 12'd656;  w_h_se = 12'd752;  w_h_tot = 12'd800;
    w_v_act = 12'd480;  w_v_ss = 12'd490;  w_v_se = 12'd492;  w_v_tot = 12'd525;
    w_pol   = 1'b0;
    case (r_mode)
      4'd0: begin
        w_h_act = 12'd640;  w_h_ss = 12'd656;  w_h_se = 12'd752;  w_h_tot = 12'd800;
        w_v_act = 12'd480;  w_v_ss = 12'd490;  w_v_se = 12'd492;  w_v_tot = 12'd525;
        w_pol   = 1'b0;
      end
      4'd1: begin
        w_h_act = 12'd800;  w_h_ss = 12'd840;  w_h_se = 12'd968;  w_h_tot = 12'd1056;
        w_v_act = 12'd600;  w_v_ss = 12'd601;  w_v_se = 12'd605;  w_v_tot = 12'd628;
        w_pol   = 1'b1;
      end
      4'd2: begin
        w_h_act = 12'd1024; w_h_ss = 12'd1048; w_h_se = 12'd1184; w_h_tot = 12'd1344;
        w_v_act = 12'd768;  w_v_ss = 12'd771;  w_v_se = 12'd777;  w_v_tot = 12'd806;
        w_pol   = 1'b0;
      end
      default: begin
        w_h_act = 12'd640;  w_h_ss = 12'd656;  w_h_se = 12'd752;  w_h_tot = 12'd800;
        w_v_act = 12'd480;  w_v_ss = 12'd490;  w_v_se = 12'd492;  w_v_tot = 12'd525;
        w_pol   = 1'b0;
      end
    endcase
  end

  assign w_supported = (r_mode <= 4'd2);

  // Mode latch, FSM, settle counter and raster counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_SETTLE;
      r_mode   <= 4'd0;
      r_settle <= '0;
      r_h_cnt  <= 12'd0;
      r_v_cnt  <= 12'd0;
    end else if (vpg_mode_change) begin
      // A strobe in any state (including SETTLE) restarts the window.
      r_state  <= S_SETTLE;
      r_mode   <= vpg_mode;
      r_settle <= '0;
      r_h_cnt  <= 12'd0;
      r_v_cnt  <= 12'd0;
    end else begin
      case (r_state)
        S_SETTLE: begin
          r_h_cnt <= 12'd0;
          r_v_cnt <= 12'd0;
          if (r_settle == SETTLE_LAST) begin
            r_state <= w_supported ? S_RUN : S_INVALID;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        S_RUN: begin
          if (r_h_cnt == (w_h_tot - 12'd1)) begin
            r_h_cnt <= 12'd0;
            if (r_v_cnt == (w_v_tot - 12'd1)) begin
              r_v_cnt <= 12'd0;
            end else begin
              r_v_cnt <= r_v_cnt + 12'd1;
            end
          end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
          end
        end
        S_INVALID: begin
          r_h_cnt <= 12'd0;
          r_v_cnt <= 12'd0;
        end
        default: begin
          r_state  <= S_SETTLE;
          r_settle <= '0;
          r_h_cnt  <= 12'd0;
          r_v_cnt  <= 12'd0;
        end
      endcase
    end
  end

  logic w_h_active, w_v_active, w_h_sync, w_v_sync;
  logic w_hs_nxt, w_vs_nxt, w_de_nxt, w_fs_nxt;

  assign w_h_active = (r_h_cnt < w_h_act);
  assign w_v_active = (r_v_cnt < w_v_act);
  assign w_h_sync   = (r_h_cnt >= w_h_ss) && (r_h_cnt < w_h_se);
  assign w_v_sync   = (r_v_cnt >= w_v_ss) && (r_v_cnt < w_v_se);

  // Next output values decoded from the current state and counters.
  always_comb begin
    w_hs_nxt = 1'b0;
    w_vs_nxt = 1'b0;
    w_de_nxt = 1'b0;
    w_fs_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        // Asserted level equals the polarity bit; deasserted is its inverse.
        w_hs_nxt = w_h_sync ? w_pol : ~w_pol;
        w_vs_nxt = w_v_sync ? w_pol : ~w_pol;
        w_de_nxt = w_h_active && w_v_active;
        w_fs_nxt = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
      end
      S_SETTLE: begin
        w_hs_nxt = ~w_pol;
        w_vs_nxt = ~w_pol;
      end
      S_INVALID: begin
        w_hs_nxt = 1'b0;
        w_vs_nxt = 1'b0;
      end
      default: begin
        w_hs_nxt = 1'b0;
        w_vs_nxt = 1'b0;
      end
    endcase
  end

  // Registered timing outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      mode_valid  <= 1'b1;
    end else begin
      hsync       <= w_hs_nxt;
      vsync       <= w_vs_nxt;
      de          <= w_de_nxt;
      frame_start <= w_fs_nxt;
      mode_valid  <= w_supported;
    end
  end

`ifdef VTG_PIXEL_POS_EN
  logic [11:0] r_x, r_y;

  // Registered pixel coordinates, forced to 0 outside active video.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= 12'd0;
      r_y <= 12'd0;
    end else begin
      r_x <= w_de_nxt ? r_h_cnt : 12'd0;
      r_y <= w_de_nxt ? r_v_cnt : 12'd0;
    end
  end

  assign x = r_x;
  assign y = r_y;
`else
  assign x = 12'd0;
  assign y = 12'd0;
`endif

endmodule
